// File: rtl/smi_header_extract_pf2.sv
// rtl/smi_header_extract_pf2.sv - strip a 1..2 flit header from SMI frames and realign the payload
//
// Ports:
//   clk, srstn                        clock, asynchronous active-low reset
//   smiInReady/Eofc/Data, smiInStop   input SMI frame stream
//   headerReady/Data, headerStop      extracted HeadWidth-byte header word
//   smiOutReady/Eofc/Data, smiOutStop payload frame, byte-realigned to offset 0
//   runtCount[15:0]                   discarded runt frames (only with SMI_HEADER_EXTRACT_RUNT_COUNT_EN)
// Optional feature macro: SMI_HEADER_EXTRACT_RUNT_COUNT_EN

module smi_header_extract_pf2 #(
    parameter int FlitWidth     = 8,
    parameter int HeadWidth     = 14,
    parameter int FifoSize      = 16,
    parameter int FifoIndexSize = 4
) (
    input  logic                   clk,
    input  logic                   srstn,
    input  logic                   smiInReady,
    input  logic [7:0]             smiInEofc,
    input  logic [FlitWidth*8-1:0] smiInData,
    output logic                   smiInStop,
    output logic                   headerReady,
    output logic [HeadWidth*8-1:0] headerData,
    input  logic                   headerStop,
    output logic                   smiOutReady,
    output logic [7:0]             smiOutEofc,
    output logic [FlitWidth*8-1:0] smiOutData,
    input  logic                   smiOutStop
`ifdef SMI_HEADER_EXTRACT_RUNT_COUNT_EN
    ,
    output logic [15:0]            runtCount
`endif
);

    localparam int Head2Width = HeadWidth - FlitWidth;
    localparam int FlitSplit  = FlitWidth - Head2Width;

    localparam logic [7:0] Head2Eofc = 8'(Head2Width);
    localparam logic [7:0] SplitEofc = 8'(FlitSplit);
    localparam logic [7:0] EofcMask  = 8'(2 * FlitWidth - 1);

    localparam logic [FifoIndexSize-1:0] LastIdx  = FifoIndexSize'(FifoSize - 1);
    localparam logic [FifoIndexSize-1:0] PtrOne   = FifoIndexSize'(1);
    localparam logic [FifoIndexSize:0]   CountOne = (FifoIndexSize + 1)'(1);
    // One slot of headroom covers the push already sitting in the write stage.
    localparam logic [FifoIndexSize:0]   StopLevel = (FifoIndexSize + 1)'(FifoSize - 1);

    typedef enum logic [1:0] {
        HeadLow,
        HeadHigh,
        Copy,
        Tail
    } stateT;

    stateT state, nextState;

    // Input hold stage
    logic                   inValid;
    logic [7:0]             inEofc;
    logic [FlitWidth*8-1:0] inData;

    // Frame datapath
    logic [FlitWidth*8-1:0] hdrLow;
    logic [FlitSplit*8-1:0] carry;
    logic [7:0]             tailEofc;
    logic                   hdrValid;

    // FSM controls
    logic                   accept;
    logic                   halt;
    logic                   push;
    logic [FlitWidth*8-1:0] pushData;
    logic [7:0]             pushEofc;
    logic                   loadLow;
    logic                   loadHdr;
    logic                   loadCarry;
    logic                   loadTail;

    // Write stage and FIFO
    logic                     wrValid;
    logic [FlitWidth*8-1:0]   wrData;
    logic [7:0]               wrEofc;
    logic [FlitWidth*8-1:0]   fifoData [FifoSize];
    logic [7:0]               fifoEofc [FifoSize];
    logic [FifoIndexSize-1:0] wrPtr;
    logic [FifoIndexSize-1:0] rdPtr;
    logic [FifoIndexSize:0]   count;
    logic                     fifoStop;
    logic                     pop;

    assign smiInStop   = inValid & halt;
    assign headerReady = hdrValid;
    assign fifoStop    = (count >= StopLevel);
    assign smiOutReady = (count != '0);
    assign smiOutData  = fifoData[rdPtr];
    assign smiOutEofc  = fifoEofc[rdPtr];
    assign pop         = smiOutReady & ~smiOutStop;

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            inValid <= 1'b0;
        end else if (!smiInStop) begin
            inValid <= smiInReady;
        end
    end

    always_ff @(posedge clk) begin
        if (!smiInStop && smiInReady) begin
            inEofc <= smiInEofc & EofcMask;
            inData <= smiInData;
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state <= HeadLow;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        halt      = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        pushData  = '0;
        pushEofc  = '0;
        loadLow   = 1'b0;
        loadHdr   = 1'b0;
        loadCarry = 1'b0;
        loadTail  = 1'b0;
        case (state)
            HeadLow: begin
                accept  = inValid;
                loadLow = inValid;
                // A last flit here means the whole frame fits inside one flit: runt.
                if (inValid && inEofc == 8'd0) begin
                    nextState = HeadHigh;
                end
            end
            HeadHigh: begin
                // A full header reg that is draining this cycle may be reloaded.
                halt   = hdrValid & headerStop;
                accept = inValid & ~halt;
                if (accept) begin
                    loadCarry = 1'b1;
                    if (inEofc == 8'd0) begin
                        loadHdr   = 1'b1;
                        nextState = Copy;
                    end else if (inEofc <= Head2Eofc) begin
                        nextState = HeadLow;
                    end else begin
                        loadHdr   = 1'b1;
                        loadTail  = 1'b1;
                        nextState = Tail;
                    end
                end
            end
            Copy: begin
                halt   = fifoStop;
                accept = inValid & ~halt;
                if (accept) begin
                    push      = 1'b1;
                    pushData  = {inData[Head2Width*8-1:0], carry};
                    loadCarry = 1'b1;
                    if (inEofc == 8'd0) begin
                        pushEofc = 8'd0;
                    end else if (inEofc <= Head2Eofc) begin
                        // The carried bytes plus this flit's bytes all fit in one output flit.
                        pushEofc  = SplitEofc + inEofc;
                        nextState = HeadLow;
                    end else begin
                        pushEofc  = 8'd0;
                        loadTail  = 1'b1;
                        nextState = Tail;
                    end
                end
            end
            Tail: begin
                halt     = 1'b1;
                push     = ~fifoStop;
                pushData = {{(Head2Width*8){1'b0}}, carry};
                pushEofc = tailEofc;
                if (!fifoStop) begin
                    nextState = HeadLow;
                end
            end
            default: begin
                nextState = HeadLow;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (loadLow) begin
            hdrLow <= inData;
        end
        if (loadCarry) begin
            carry <= inData[FlitWidth*8-1 -: FlitSplit*8];
        end
        if (loadTail) begin
            tailEofc <= inEofc - Head2Eofc;
        end
        if (loadHdr) begin
            headerData <= {inData[Head2Width*8-1:0], hdrLow};
        end
        if (push) begin
            wrData <= pushData;
            wrEofc <= pushEofc;
        end
        if (wrValid) begin
            fifoData[wrPtr] <= wrData;
            fifoEofc[wrPtr] <= wrEofc;
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            hdrValid <= 1'b0;
        end else if (loadHdr) begin
            hdrValid <= 1'b1;
        end else if (!headerStop) begin
            hdrValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            wrValid <= 1'b0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
        end else begin
            wrValid <= push;
            if (wrValid) begin
                wrPtr <= (wrPtr == LastIdx) ? '0 : wrPtr + PtrOne;
            end
            if (pop) begin
                rdPtr <= (rdPtr == LastIdx) ? '0 : rdPtr + PtrOne;
            end
            case ({wrValid, pop})
                2'b10:   count <= count + CountOne;
                2'b01:   count <= count - CountOne;
                default: count <= count;
            endcase
        end
    end

`ifdef SMI_HEADER_EXTRACT_RUNT_COUNT_EN
    logic runt;

    assign runt = accept &&
                  (((state == HeadLow) && (inEofc != 8'd0)) ||
                   ((state == HeadHigh) && (inEofc != 8'd0) && (inEofc <= Head2Eofc)));

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            runtCount <= '0;
        end else if (runt && runtCount != 16'hFFFF) begin
            runtCount <= runtCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_smi_header_extract_pf2.sv
// tb/tb_smi_header_extract_pf2.sv - directed self-checking bench for smi_header_extract_pf2
`timescale 1ns/1ps

module tb_smi_header_extract_pf2;

    logic         clk = 1'b0;
    logic         srstn;
    logic         smiInReady;
    logic [7:0]   smiInEofc;
    logic [63:0]  smiInData;
    logic         smiInStop;
    logic         headerReady;
    logic [111:0] headerData;
    logic         headerStop;
    logic         smiOutReady;
    logic [7:0]   smiOutEofc;
    logic [63:0]  smiOutData;
    logic         smiOutStop;
`ifdef SMI_HEADER_EXTRACT_RUNT_COUNT_EN
    logic [15:0]  runtCount;
`endif

    int nChecks = 0;
    int nFail   = 0;

    logic [111:0] hdrQ[$];
    logic [111:0] expHdr[$];
    logic [63:0]  payD[$];
    logic [63:0]  expPayD[$];
    logic [7:0]   payE[$];
    logic [7:0]   expPayE[$];

    smi_header_extract_pf2 dut (
        .clk         (clk),
        .srstn       (srstn),
        .smiInReady  (smiInReady),
        .smiInEofc   (smiInEofc),
        .smiInData   (smiInData),
        .smiInStop   (smiInStop),
        .headerReady (headerReady),
        .headerData  (headerData),
        .headerStop  (headerStop),
        .smiOutReady (smiOutReady),
        .smiOutEofc  (smiOutEofc),
        .smiOutData  (smiOutData),
        .smiOutStop  (smiOutStop)
`ifdef SMI_HEADER_EXTRACT_RUNT_COUNT_EN
        ,
        .runtCount   (runtCount)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (srstn && headerReady && !headerStop) begin
            hdrQ.push_back(headerData);
        end
        if (srstn && smiOutReady && !smiOutStop) begin
            payD.push_back(smiOutData);
            payE.push_back(smiOutEofc);
        end
    end

    function automatic logic [63:0] flitData(input int base, input int len, input int f);
        logic [63:0] d;
        for (int j = 0; j < 8; j++) begin
            d[j*8 +: 8] = (8*f + j < len) ? 8'(base + 8*f + j) : 8'hEE;
        end
        return d;
    endfunction

    function automatic logic [7:0] flitEofc(input int len, input int f);
        return (f == (len + 7) / 8 - 1) ? 8'(len - 8*f) : 8'h00;
    endfunction

    function automatic logic [63:0] byteMask(input logic [7:0] e);
        return (e == 8'd0) ? '1 : ((64'd1 << (8 * int'(e))) - 64'd1);
    endfunction

    task automatic clearAll();
        hdrQ.delete();
        expHdr.delete();
        payD.delete();
        expPayD.delete();
        payE.delete();
        expPayE.delete();
    endtask

    // Frame bytes are base+i; header is bytes 0..13, payload bytes 14.. packed eight per flit.
    task automatic expectFrame(input int base, input int len);
        logic [111:0] h;
        logic [63:0]  d;
        int rem;
        int k;
        for (int j = 0; j < 14; j++) begin
            h[j*8 +: 8] = 8'(base + j);
        end
        expHdr.push_back(h);
        rem = len - 14;
        k = 0;
        while (rem > 0) begin
            for (int j = 0; j < 8; j++) begin
                d[j*8 +: 8] = 8'(base + 14 + 8*k + j);
            end
            expPayD.push_back(d);
            expPayE.push_back((rem > 8) ? 8'd0 : 8'(rem));
            rem = rem - 8;
            k++;
        end
    endtask

    task automatic sendFlit(input logic [63:0] d, input logic [7:0] e);
        bit st;
        int guard;
        guard = 0;
        smiInReady = 1'b1;
        smiInData  = d;
        smiInEofc  = e;
        do begin
            @(negedge clk);
            st = smiInStop;
            @(posedge clk);
            guard++;
        end while (st && guard < 1000);
        #1;
        nChecks++;
        if (st) begin
            nFail++;
            $display("FAIL sendFlit stuck: smiInStop=%0b after %0d cycles, required 0", st, guard);
        end
    endtask

    task automatic sendFrame(input int base, input int len);
        for (int f = 0; f < (len + 7) / 8; f++) begin
            sendFlit(flitData(base, len, f), flitEofc(len, f));
        end
    endtask

    task automatic waitOutputs();
        for (int c = 0; c < 400; c++) begin
            if (hdrQ.size() >= expHdr.size() && payD.size() >= expPayD.size()) break;
            @(posedge clk);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        nChecks++;
        if (smiInStop !== 1'b0) begin nFail++; $display("FAIL reset smiInStop got %b want 0", smiInStop); end
        nChecks++;
        if (headerReady !== 1'b0) begin nFail++; $display("FAIL reset headerReady got %b want 0", headerReady); end
        nChecks++;
        if (smiOutReady !== 1'b0) begin nFail++; $display("FAIL reset smiOutReady got %b want 0", smiOutReady); end
`ifdef SMI_HEADER_EXTRACT_RUNT_COUNT_EN
        nChecks++;
        if (runtCount !== 16'd0) begin nFail++; $display("FAIL reset runtCount got %0d want 0", runtCount); end
`endif
        srstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame_lengths();
        int lens[5] = '{32, 20, 16, 30, 15};
        logic [63:0] m;
        clearAll();
        for (int i = 0; i < 5; i++) begin
            expectFrame(16 * i + 8, lens[i]);
        end
        for (int i = 0; i < 5; i++) begin
            sendFrame(16 * i + 8, lens[i]);
        end
        smiInReady = 1'b0;
        waitOutputs();
        nChecks++;
        if (hdrQ.size() != expHdr.size()) begin nFail++; $display("FAIL lengths hdrCount got %0d want %0d", hdrQ.size(), expHdr.size()); end
        for (int i = 0; i < expHdr.size() && i < hdrQ.size(); i++) begin
            nChecks++;
            if (hdrQ[i] !== expHdr[i]) begin nFail++; $display("FAIL lengths hdr%0d got %h want %h", i, hdrQ[i], expHdr[i]); end
        end
        nChecks++;
        if (payD.size() != expPayD.size()) begin nFail++; $display("FAIL lengths payCount got %0d want %0d", payD.size(), expPayD.size()); end
        for (int i = 0; i < expPayD.size() && i < payD.size(); i++) begin
            m = byteMask(expPayE[i]);
            nChecks++;
            if (payE[i] !== expPayE[i] || (payD[i] & m) !== (expPayD[i] & m)) begin
                nFail++;
                $display("FAIL lengths pay%0d got %h/eofc%0d want %h/eofc%0d", i, payD[i] & m, payE[i], expPayD[i] & m, expPayE[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic [63:0] m;
        clearAll();
        expectFrame(8'h40, 32);
        sendFlit(flitData(8'h40, 32, 0), flitEofc(32, 0));
        sendFlit(flitData(8'h40, 32, 1), flitEofc(32, 1));
        smiInData = flitData(8'h40, 32, 2);
        smiInEofc = flitEofc(32, 2);
        @(negedge clk);
        nChecks++;
        if (smiInStop !== 1'b0) begin nFail++; $display("FAIL latency flit2 stop got %b want 0", smiInStop); end
        @(posedge clk);
        #1;
        smiInReady = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            nChecks++;
            if (smiOutReady !== (c == 3)) begin
                nFail++;
                $display("FAIL latency cycle%0d smiOutReady got %b want %b", c, smiOutReady, (c == 3));
            end
        end
        @(posedge clk);
        #1;
        sendFlit(flitData(8'h40, 32, 3), flitEofc(32, 3));
        smiInReady = 1'b0;
        waitOutputs();
        nChecks++;
        if (hdrQ.size() != 1 || hdrQ[0] !== expHdr[0]) begin nFail++; $display("FAIL latency header count %0d want 1 matching %h", hdrQ.size(), expHdr[0]); end
        nChecks++;
        if (payD.size() != expPayD.size()) begin nFail++; $display("FAIL latency payCount got %0d want %0d", payD.size(), expPayD.size()); end
        for (int i = 0; i < expPayD.size() && i < payD.size(); i++) begin
            m = byteMask(expPayE[i]);
            nChecks++;
            if (payE[i] !== expPayE[i] || (payD[i] & m) !== (expPayD[i] & m)) begin
                nFail++;
                $display("FAIL latency pay%0d got %h/eofc%0d want %h/eofc%0d", i, payD[i] & m, payE[i], expPayD[i] & m, expPayE[i]);
            end
        end
    endtask

    task automatic test_runts();
        logic [63:0] m;
        clearAll();
        expectFrame(8'hA0, 16);
        sendFrame(8'h80, 5);
        sendFrame(8'h90, 14);
        sendFrame(8'hA0, 16);
        smiInReady = 1'b0;
        waitOutputs();
        nChecks++;
        if (hdrQ.size() != 1) begin nFail++; $display("FAIL runts hdrCount got %0d want 1", hdrQ.size()); end
        else begin
            nChecks++;
            if (hdrQ[0] !== expHdr[0]) begin nFail++; $display("FAIL runts hdr got %h want %h", hdrQ[0], expHdr[0]); end
        end
        nChecks++;
        if (payD.size() != 1) begin nFail++; $display("FAIL runts payCount got %0d want 1", payD.size()); end
        else begin
            m = byteMask(expPayE[0]);
            nChecks++;
            if (payE[0] !== expPayE[0] || (payD[0] & m) !== (expPayD[0] & m)) begin
                nFail++;
                $display("FAIL runts pay got %h/eofc%0d want %h/eofc%0d", payD[0] & m, payE[0], expPayD[0] & m, expPayE[0]);
            end
        end
`ifdef SMI_HEADER_EXTRACT_RUNT_COUNT_EN
        nChecks++;
        if (runtCount !== 16'd2) begin nFail++; $display("FAIL runts runtCount got %0d want 2", runtCount); end
`endif
    endtask

    task automatic test_header_stall();
        logic [63:0] m;
        bit sawStop;
        int hdrDuring;
        sawStop = 1'b0;
        hdrDuring = 0;
        clearAll();
        expectFrame(8'h10, 32);
        expectFrame(8'h50, 24);
        headerStop = 1'b1;
        fork
            begin
                sendFrame(8'h10, 32);
                sendFrame(8'h50, 24);
                smiInReady = 1'b0;
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (smiInStop) sawStop = 1'b1;
                end
                hdrDuring = hdrQ.size();
                @(posedge clk);
                #1;
                headerStop = 1'b0;
            end
            begin
                for (int c = 0; c < 120; c++) begin
                    @(posedge clk);
                    #1;
                    smiOutStop = 1'($urandom_range(0, 1));
                end
                smiOutStop = 1'b0;
            end
        join
        waitOutputs();
        nChecks++;
        if (sawStop !== 1'b1) begin nFail++; $display("FAIL stall smiInStop seen got %b want 1", sawStop); end
        nChecks++;
        if (hdrDuring != 0) begin nFail++; $display("FAIL stall headers while stopped got %0d want 0", hdrDuring); end
        nChecks++;
        if (hdrQ.size() != expHdr.size()) begin nFail++; $display("FAIL stall hdrCount got %0d want %0d", hdrQ.size(), expHdr.size()); end
        for (int i = 0; i < expHdr.size() && i < hdrQ.size(); i++) begin
            nChecks++;
            if (hdrQ[i] !== expHdr[i]) begin nFail++; $display("FAIL stall hdr%0d got %h want %h", i, hdrQ[i], expHdr[i]); end
        end
        nChecks++;
        if (payD.size() != expPayD.size()) begin nFail++; $display("FAIL stall payCount got %0d want %0d", payD.size(), expPayD.size()); end
        for (int i = 0; i < expPayD.size() && i < payD.size(); i++) begin
            m = byteMask(expPayE[i]);
            nChecks++;
            if (payE[i] !== expPayE[i] || (payD[i] & m) !== (expPayD[i] & m)) begin
                nFail++;
                $display("FAIL stall pay%0d got %h/eofc%0d want %h/eofc%0d", i, payD[i] & m, payE[i], expPayD[i] & m, expPayE[i]);
            end
        end
    endtask

    task automatic test_reset_mid_copy();
        logic [63:0] m;
        clearAll();
        headerStop = 1'b1;
        smiOutStop = 1'b1;
        sendFlit(flitData(8'hC0, 32, 0), flitEofc(32, 0));
        sendFlit(flitData(8'hC0, 32, 1), flitEofc(32, 1));
        sendFlit(flitData(8'hC0, 32, 2), flitEofc(32, 2));
        smiInReady = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        nChecks++;
        if (headerReady !== 1'b1 || smiOutReady !== 1'b1) begin
            nFail++;
            $display("FAIL midreset pre headerReady=%b smiOutReady=%b want 1/1", headerReady, smiOutReady);
        end
        srstn = 1'b0;
        #1;
        nChecks++;
        if (smiOutReady !== 1'b0) begin nFail++; $display("FAIL midreset smiOutReady got %b want 0", smiOutReady); end
        nChecks++;
        if (headerReady !== 1'b0) begin nFail++; $display("FAIL midreset headerReady got %b want 0", headerReady); end
        nChecks++;
        if (smiInStop !== 1'b0) begin nFail++; $display("FAIL midreset smiInStop got %b want 0", smiInStop); end
`ifdef SMI_HEADER_EXTRACT_RUNT_COUNT_EN
        nChecks++;
        if (runtCount !== 16'd0) begin nFail++; $display("FAIL midreset runtCount got %0d want 0", runtCount); end
`endif
        headerStop = 1'b0;
        smiOutStop = 1'b0;
        @(posedge clk);
        #1;
        srstn = 1'b1;
        @(posedge clk);
        #1;
        clearAll();
        expectFrame(8'hD0, 32);
        sendFrame(8'hD0, 32);
        smiInReady = 1'b0;
        waitOutputs();
        nChecks++;
        if (hdrQ.size() != 1 || hdrQ[0] !== expHdr[0]) begin nFail++; $display("FAIL midreset header count %0d want 1 matching %h", hdrQ.size(), expHdr[0]); end
        nChecks++;
        if (payD.size() != expPayD.size()) begin nFail++; $display("FAIL midreset payCount got %0d want %0d", payD.size(), expPayD.size()); end
        for (int i = 0; i < expPayD.size() && i < payD.size(); i++) begin
            m = byteMask(expPayE[i]);
            nChecks++;
            if (payE[i] !== expPayE[i] || (payD[i] & m) !== (expPayD[i] & m)) begin
                nFail++;
                $display("FAIL midreset pay%0d got %h/eofc%0d want %h/eofc%0d", i, payD[i] & m, payE[i], expPayD[i] & m, expPayE[i]);
            end
        end
    endtask

    initial begin
        srstn      = 1'b1;
        smiInReady = 1'b0;
        smiInEofc  = 8'd0;
        smiInData  = '0;
        headerStop = 1'b0;
        smiOutStop = 1'b0;
        #3;
        srstn = 1'b0;
        test_reset();
        test_frame_lengths();
        test_latency();
        test_runts();
        test_header_stall();
        test_reset_mid_copy();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
